// File: rtl/fsmc_mux_slave_if.sv
// fsmc_mux_slave_if
//   Register-side bus of the FSMC bridge: the decoded address/chip selects,
//   write strobe and data, and the read request/return path.
//   The parameters must match the ones given to fsmc_mux_slave.
//
//   addr     latched transaction address
//   cs       one-hot region select
//   wr_data  captured write data
//   wr_valid one-cycle write strobe
//   rd_req   one-cycle read request
//   rd_data  read data from the selected region, valid the cycle after rd_req
//
//   modport master : the bridge (drives requests, receives rd_data)
//   modport slave  : a register file / region decoder
interface fsmc_mux_slave_if #(
    parameter int AD_W   = 18,
    parameter int DATA_W = 16,
    parameter int NUM_CS = 4
);
    logic [AD_W-1:0]   addr;
    logic [NUM_CS-1:0] cs;
    logic [DATA_W-1:0] wr_data;
    logic              wr_valid;
    logic              rd_req;
    logic [DATA_W-1:0] rd_data;

    modport master (
        output addr, cs, wr_data, wr_valid, rd_req,
        input  rd_data
    );

    modport slave (
        input  addr, cs, wr_data, wr_valid, rd_req,
        output rd_data
    );
endinterface

// File: rtl/fsmc_mux_slave.sv
// fsmc_mux_slave
//   Slave for an MCU FSMC multiplexed address/data bus. The MCU strobes and
//   the AD bus are synchronised into clk, edge-detected, and turned into a
//   latched address, one-hot region selects and single-cycle write / read
//   request strobes on the register-side interface.
//
//   Optional feature macro: FSMC_BURST_EN
//     defined   : every completed write or read advances addr by one
//                 (wrapping) and re-decodes cs, so several strobes may follow
//                 one NADV pulse.
//     undefined : addr is fixed until the next NADV.
//
// Ports
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   NADV     address valid, active low
//   NWE      write strobe, active low
//   NOE      read strobe, active low
//   AD       multiplexed address/data bus (driven only during reads)
//   regs     register-side bus (fsmc_mux_slave_if.master)
//   state    current FSM encoding, for debug
//   err      sticky flag: an access hit a region index >= NUM_CS
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | no transaction
// ADDR     | NADV low, waiting for it to rise to latch the address
// WAIT     | address latched, waiting for a strobe or the idle timeout
// WRITE    | NWE low, data captured on its rising edge
// READ_REQ | rd_req pulse issued to the selected region
// READ_DRV | read data registered and driven onto AD while NOE is low
module fsmc_mux_slave #(
    parameter int AD_W        = 18,
    parameter int DATA_W      = 16,
    parameter int NUM_CS      = 4,
    parameter int CS_LSB      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             NADV,
    input  logic             NWE,
    input  logic             NOE,
    inout  wire [AD_W-1:0]   AD,
    fsmc_mux_slave_if.master regs,
    output logic [2:0]       state,
    output logic             err
);
    localparam int IDX_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
    localparam logic [3:0] TIMEOUT = 4'd15;

    if (DATA_W > AD_W) begin : g_chk_data_w
        $error("fsmc_mux_slave: DATA_W must not exceed AD_W");
    end
    if (NUM_CS < 1 || NUM_CS > 16) begin : g_chk_num_cs
        $error("fsmc_mux_slave: NUM_CS must be 1..16");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_chk_sync
        $error("fsmc_mux_slave: SYNC_STAGES must be 2..4");
    end
    if (CS_LSB + IDX_W > AD_W) begin : g_chk_idx
        $error("fsmc_mux_slave: region index field overflows AD_W");
    end

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR     = 3'd1,
        WAIT     = 3'd2,
        WRITE    = 3'd3,
        READ_REQ = 3'd4,
        READ_DRV = 3'd5
    } state_t;

    function automatic logic idx_ok(input logic [IDX_W-1:0] idx);
        return (NUM_CS == 1) || ({1'b0, idx} < (IDX_W+1)'(NUM_CS));
    endfunction

    // Indices >= NUM_CS match no bit, so out-of-range yields cs = 0.
    function automatic logic [NUM_CS-1:0] decode_cs(input logic [IDX_W-1:0] idx);
        logic [NUM_CS-1:0] c;
        c = '0;
        for (int i = 0; i < NUM_CS; i++) begin
            c[i] = (NUM_CS == 1) || (idx == IDX_W'(i));
        end
        return c;
    endfunction

    // Synchronisers; strobes reset to their inactive (high) level so that
    // reset release never looks like a falling edge.
    logic [SYNC_STAGES-1:0] nadv_s, nwe_s, noe_s;
    logic [AD_W-1:0]        ad_s [SYNC_STAGES];
    logic                   nadv_d, nwe_d, noe_d;
    logic [DATA_W-1:0]      wdat_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            nadv_s <= '1;
            nwe_s  <= '1;
            noe_s  <= '1;
            for (int i = 0; i < SYNC_STAGES; i++) ad_s[i] <= '0;
            nadv_d <= 1'b1;
            nwe_d  <= 1'b1;
            noe_d  <= 1'b1;
            wdat_d <= '0;
        end else begin
            nadv_s  <= {nadv_s[SYNC_STAGES-2:0], NADV};
            nwe_s   <= {nwe_s[SYNC_STAGES-2:0], NWE};
            noe_s   <= {noe_s[SYNC_STAGES-2:0], NOE};
            ad_s[0] <= AD;
            for (int i = 1; i < SYNC_STAGES; i++) ad_s[i] <= ad_s[i-1];
            nadv_d  <= nadv_s[SYNC_STAGES-1];
            nwe_d   <= nwe_s[SYNC_STAGES-1];
            noe_d   <= noe_s[SYNC_STAGES-1];
            // data sample aligned with nwe_d, i.e. the last one before NWE rose
            wdat_d  <= ad_s[SYNC_STAGES-1][DATA_W-1:0];
        end
    end

    logic            nadv_y, nwe_y, noe_y;
    logic [AD_W-1:0] ad_y;
    logic            nadv_fall, nadv_rise, nwe_rise, noe_rise;

    assign nadv_y    = nadv_s[SYNC_STAGES-1];
    assign nwe_y     = nwe_s[SYNC_STAGES-1];
    assign noe_y     = noe_s[SYNC_STAGES-1];
    assign ad_y      = ad_s[SYNC_STAGES-1];
    assign nadv_fall = !nadv_y && nadv_d;
    assign nadv_rise = nadv_y && !nadv_d;
    assign nwe_rise  = nwe_y && !nwe_d;
    assign noe_rise  = noe_y && !noe_d;

    state_t            st;
    logic [AD_W-1:0]   addr_q;
    logic [NUM_CS-1:0] cs_q;
    logic              in_range;
    logic [DATA_W-1:0] wr_data_q;
    logic              wr_valid_q;
    logic              rd_req_q;
    logic [DATA_W-1:0] dout;
    logic              rd_cap;
    logic [3:0]        timer;
    logic              err_q;

`ifdef FSMC_BURST_EN
    // The increment is deferred one cycle so addr still names the written
    // location while wr_valid is high.
    logic            bump;
    logic [AD_W-1:0] addr_inc;
    assign addr_inc = addr_q + 1'b1;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st         <= IDLE;
            addr_q     <= '0;
            cs_q       <= '0;
            in_range   <= 1'b0;
            wr_data_q  <= '0;
            wr_valid_q <= 1'b0;
            rd_req_q   <= 1'b0;
            dout       <= '0;
            rd_cap     <= 1'b0;
            timer      <= '0;
            err_q      <= 1'b0;
`ifdef FSMC_BURST_EN
            bump       <= 1'b0;
`endif
        end else begin
            wr_valid_q <= 1'b0;
            rd_req_q   <= 1'b0;
            if (nadv_fall) begin
                // new address phase; aborts whatever was in progress
                st       <= ADDR;
                cs_q     <= '0;
                in_range <= 1'b0;
                rd_cap   <= 1'b0;
`ifdef FSMC_BURST_EN
                bump     <= 1'b0;
`endif
            end else begin
                case (st)
                    IDLE: ;
                    ADDR: begin
                        if (nadv_rise) begin
                            addr_q   <= ad_y;
                            cs_q     <= decode_cs(ad_y[CS_LSB +: IDX_W]);
                            in_range <= idx_ok(ad_y[CS_LSB +: IDX_W]);
                            timer    <= TIMEOUT;
                            st       <= WAIT;
                        end
                    end
                    WAIT: begin
`ifdef FSMC_BURST_EN
                        if (bump) begin
                            bump     <= 1'b0;
                            addr_q   <= addr_inc;
                            cs_q     <= decode_cs(addr_inc[CS_LSB +: IDX_W]);
                            in_range <= idx_ok(addr_inc[CS_LSB +: IDX_W]);
                        end
`endif
                        if (!nwe_y) begin
                            // write wins when both strobes are low
                            st <= WRITE;
                        end else if (!noe_y) begin
                            st       <= READ_REQ;
                            rd_req_q <= 1'b1;
                            if (!in_range) err_q <= 1'b1;
                        end else if (timer == '0) begin
                            st       <= IDLE;
                            cs_q     <= '0;
                            in_range <= 1'b0;
                        end else begin
                            timer <= timer - 1'b1;
                        end
                    end
                    WRITE: begin
                        if (nwe_rise) begin
                            wr_data_q  <= wdat_d;
                            wr_valid_q <= in_range;
                            if (!in_range) err_q <= 1'b1;
                            timer      <= TIMEOUT;
                            st         <= WAIT;
`ifdef FSMC_BURST_EN
                            bump       <= 1'b1;
`endif
                        end
                    end
                    READ_REQ: begin
                        st     <= READ_DRV;
                        rd_cap <= 1'b1;
                    end
                    READ_DRV: begin
                        // region returns data the cycle after rd_req
                        if (rd_cap) begin
                            dout   <= in_range ? regs.rd_data : '0;
                            rd_cap <= 1'b0;
                        end
                        if (noe_rise) begin
                            timer <= TIMEOUT;
                            st    <= WAIT;
`ifdef FSMC_BURST_EN
                            bump  <= 1'b1;
`endif
                        end
                    end
                    default: st <= IDLE;
                endcase
            end
        end
    end

    // Raw NOE gates the driver so the bus is released the moment the MCU
    // ends the read, without waiting for the synchroniser.
    logic ad_oe;
    assign ad_oe = (st == READ_DRV) && !NOE;
    assign AD    = ad_oe ? AD_W'(dout) : 'z;

    assign regs.addr     = addr_q;
    assign regs.cs       = cs_q;
    assign regs.wr_data  = wr_data_q;
    assign regs.wr_valid = wr_valid_q;
    assign regs.rd_req   = rd_req_q;
    assign state         = st;
    assign err           = err_q;
endmodule

// File: tb/tb_fsmc_mux_slave.sv
module tb_fsmc_mux_slave;
    localparam int AD_W        = 18;
    localparam int DATA_W      = 16;
    localparam int NUM_CS      = 3;
    localparam int CS_LSB      = 16;
    localparam int SYNC_STAGES = 2;
`ifdef FSMC_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset_n;
    logic              nadv, nwe, noe;
    logic              tb_oe;
    logic [AD_W-1:0]   tb_ad;
    wire  [AD_W-1:0]   ad_bus;
    logic [2:0]        state;
    logic              err;

    int total = 0;
    int bad   = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    int base_wr, base_rd;

    logic [AD_W+DATA_W-1:0] exp_q [$];

    always #5 clk = ~clk;

    assign ad_bus = tb_oe ? tb_ad : 'z;

    fsmc_mux_slave_if #(.AD_W(AD_W), .DATA_W(DATA_W), .NUM_CS(NUM_CS)) bus ();

    fsmc_mux_slave #(
        .AD_W(AD_W), .DATA_W(DATA_W), .NUM_CS(NUM_CS),
        .CS_LSB(CS_LSB), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .NADV(nadv), .NWE(nwe), .NOE(noe), .AD(ad_bus),
        .regs(bus), .state(state), .err(err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic addr_phase(input logic [AD_W-1:0] a);
        tb_ad = a;
        tb_oe = 1'b1;
        nadv  = 1'b0;
        cyc(4);
        nadv = 1'b1;
        cyc(4);
        tb_oe = 1'b0;
    endtask

    task automatic do_write(input logic [DATA_W-1:0] d);
        tb_ad = AD_W'(d);
        tb_oe = 1'b1;
        nwe   = 1'b0;
        cyc(4);
        nwe = 1'b1;
        cyc(1);
        tb_oe = 1'b0;
        cyc(4);
    endtask

    // Scoreboard: each wr_valid must match the oldest expected {addr, data}.
    always @(negedge clk) begin
        if (bus.wr_valid) begin
            logic [AD_W+DATA_W-1:0] e;
            wr_cnt++;
            total++;
            assert (exp_q.size() != 0) else begin
                bad++;
                $error("FAIL sb_unexpected_wr observed_addr=0x%0h expected=none", bus.addr);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_addr", 32'(bus.addr), 32'(e[AD_W+DATA_W-1:DATA_W]));
                check("sb_data", 32'(bus.wr_data), 32'(e[DATA_W-1:0]));
            end
        end
        if (bus.rd_req) rd_cnt++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        nadv = 1'b1; nwe = 1'b1; noe = 1'b1;
        tb_oe = 1'b1;
        tb_ad = 18'h3FFFF;
        bus.rd_data = '0;
        cyc(3);

        // reset
        check("rst_state", 32'(state), 32'd0);
        check("rst_addr", 32'(bus.addr), 32'd0);
        check("rst_cs", 32'(bus.cs), 32'd0);
        check("rst_wr_valid", 32'(bus.wr_valid), 32'd0);
        check("rst_rd_req", 32'(bus.rd_req), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_ad_oe", 32'(dut.ad_oe), 32'd0);
        tb_oe = 1'b0;
        reset_n = 1'b1;
        cyc(2);
        check("rst_idle", 32'(state), 32'd0);

        // write to region 1, with strobe latency check
        addr_phase(18'h10000);
        check("wr_state_wait", 32'(state), 32'd2);
        check("wr_addr", 32'(bus.addr), 32'h10000);
        check("wr_cs", 32'(bus.cs), 32'b010);
        base_wr = wr_cnt;
        exp_q.push_back({18'h10000, 16'h0F0F});
        tb_ad = 18'h00F0F;
        tb_oe = 1'b1;
        nwe = 1'b0;
        cyc(2);
        check("wr_lat_early", 32'(state), 32'd2);
        cyc(1);
        check("wr_lat_write", 32'(state), 32'd3);
        nwe = 1'b1;
        cyc(1);
        tb_oe = 1'b0;
        cyc(4);
        check("wr_pulse_count", 32'(wr_cnt - base_wr), 32'd1);
        check("wr_data", 32'(bus.wr_data), 32'h0F0F);
        check("wr_back_wait", 32'(state), 32'd2);

        // read from region 1
        addr_phase(18'h10000);
        bus.rd_data = 16'h2321;
        base_rd = rd_cnt;
        noe = 1'b0;
        cyc(6);
        check("rd_state_drv", 32'(state), 32'd5);
        check("rd_ad_oe", 32'(dut.ad_oe), 32'd1);
        check("rd_ad_value", 32'(ad_bus), 32'h02321);
        check("rd_req_count", 32'(rd_cnt - base_rd), 32'd1);
        noe = 1'b1;
        #1;
        check("rd_release", 32'(dut.ad_oe), 32'd0);
        cyc(4);
        check("rd_back_wait", 32'(state), 32'd2);

        // abort an unfinished write with a new address phase
        addr_phase(18'h10000);
        base_wr = wr_cnt;
        tb_ad = 18'h01234;
        tb_oe = 1'b1;
        nwe = 1'b0;
        cyc(4);
        check("ab_state_write", 32'(state), 32'd3);
        tb_ad = 18'h20000;
        nadv = 1'b0;
        cyc(4);
        check("ab_state_addr", 32'(state), 32'd1);
        nwe = 1'b1;
        cyc(3);
        nadv = 1'b1;
        cyc(4);
        tb_oe = 1'b0;
        cyc(2);
        check("ab_no_wr_valid", 32'(wr_cnt - base_wr), 32'd0);
        check("ab_addr", 32'(bus.addr), 32'h20000);
        check("ab_cs", 32'(bus.cs), 32'b100);
        check("ab_err_clear", 32'(err), 32'd0);

        // out-of-range region index 3 with NUM_CS = 3
        addr_phase(18'h30000);
        check("oor_cs_addr", 32'(bus.cs), 32'd0);
        base_wr = wr_cnt;
        do_write(16'hBEEF);
        check("oor_no_wr_valid", 32'(wr_cnt - base_wr), 32'd0);
        check("oor_err", 32'(err), 32'd1);
        check("oor_cs_after", 32'(bus.cs), 32'd0);
        bus.rd_data = 16'h5555;
        noe = 1'b0;
        cyc(6);
        check("oor_rd_zero", 32'(ad_bus), 32'd0);
        noe = 1'b1;
        cyc(4);

        // three writes after one NADV
        addr_phase(18'h00005);
        base_wr = wr_cnt;
        for (int i = 0; i < 3; i++) begin
            logic [AD_W-1:0] ea;
            ea = BURST ? AD_W'(5 + i) : AD_W'(5);
            exp_q.push_back({ea, DATA_W'(16'hA + i)});
            do_write(DATA_W'(16'hA + i));
        end
        check("burst_count", 32'(wr_cnt - base_wr), 32'd3);
        check("burst_last_data", 32'(bus.wr_data), 32'hC);
        check("burst_addr_end", 32'(bus.addr), BURST ? 32'h8 : 32'h5);
        check("burst_cs", 32'(bus.cs), 32'b001);

        // idle timeout back to IDLE
        cyc(10);
        check("to_still_wait", 32'(state), 32'd2);
        cyc(10);
        check("to_idle", 32'(state), 32'd0);
        check("to_cs_clear", 32'(bus.cs), 32'd0);

        // both strobes low: write wins, no read request
        addr_phase(18'h10000);
        base_wr = wr_cnt;
        base_rd = rd_cnt;
        exp_q.push_back({18'h10000, 16'h7777});
        tb_ad = 18'h07777;
        tb_oe = 1'b1;
        nwe = 1'b0;
        noe = 1'b0;
        cyc(4);
        check("pri_state_write", 32'(state), 32'd3);
        nwe = 1'b1;
        noe = 1'b1;
        cyc(1);
        tb_oe = 1'b0;
        cyc(4);
        check("pri_wr_count", 32'(wr_cnt - base_wr), 32'd1);
        check("pri_no_rd_req", 32'(rd_cnt - base_rd), 32'd0);

        // asynchronous reset in the middle of a driven read
        addr_phase(18'h10000);
        bus.rd_data = 16'h1111;
        noe = 1'b0;
        cyc(6);
        check("ar_state_drv", 32'(state), 32'd5);
        check("ar_ad_oe_before", 32'(dut.ad_oe), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("ar_ad_oe_released", 32'(dut.ad_oe), 32'd0);
        check("ar_state", 32'(state), 32'd0);
        check("ar_addr", 32'(bus.addr), 32'd0);
        check("ar_err", 32'(err), 32'd0);
        noe = 1'b1;
        cyc(2);
        reset_n = 1'b1;
        cyc(2);
        check("ar_idle_after", 32'(state), 32'd0);

        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fsmc_mux_slave.md
Name: fsmc_mux_slave

Overview:
Parametrised FSMC multiplexed address/data bus slave. It bridges an MCU external-memory bus (NADV/NWE/NOE plus a shared AD bus) into the FPGA clock domain. It drives one-hot chip selects for NUM_CS internal register regions and produces single-cycle write and read-request strobes. Compared with the fixed 18-bit/4-CS interface, it adds configurable widths, input synchronisation, region range checking, transaction abort and optional burst addressing.

Parameters:
AD_W, 18, width of the multiplexed AD bus
DATA_W, 16, data width; must be ≤ AD_W (AD bits above DATA_W are driven 0 on reads and ignored on writes)
NUM_CS, 4, number of decoded regions (1..16)
CS_LSB, 16, lowest AD bit of the region index field; index = addr[CS_LSB +: clog2(NUM_CS)]
SYNC_STAGES, 2, synchroniser depth for NADV/NWE/NOE/AD (2..4)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
NADV  in  1  address valid, active low
NWE  in  1  write strobe, active low
NOE  in  1  read strobe, active low
AD  inout  AD_W  multiplexed address/data bus
addr  out  AD_W  latched transaction address
cs  out  NUM_CS  one-hot region select, valid while state != IDLE
wr_data  out  DATA_W  captured write data
wr_valid  out  1  one-cycle write strobe
rd_req  out  1  one-cycle read request
rd_data  in  DATA_W  read data from selected region, valid the cycle after rd_req
state  out  3  current FSM state encoding (debug)
err  out  1  sticky flag: access to out-of-range region index

Behaviour:
- Reset: all outputs 0, AD tri-stated, state=IDLE. Reset is asynchronous and takes effect mid-transaction; AD is released in the same instant.
- NADV/NWE/NOE/AD pass through SYNC_STAGES flops (AD registered alongside the strobes). Edge detection runs on the synchronised copies. End-to-end latency is SYNC_STAGES+1 clk from pin edge to strobe.
- FSM encodings: IDLE=0, ADDR=1, WAIT=2, WRITE=3, READ_REQ=4, READ_DRV=5.
- IDLE→ADDR: synchronised NADV falls.
- ADDR→WAIT: synchronised NADV rises. addr ← synchronised AD at that edge; cs decoded.
- WAIT→WRITE: NWE low. WRITE→WAIT: NWE rising edge. wr_data ← AD[DATA_W-1:0] from the sample before that edge; wr_valid pulses for 1 clk.
- WAIT→READ_REQ: NOE low. rd_req pulses for 1 clk. The next clk goes to READ_DRV and registers rd_data into the output register.
- READ_DRV: AD is driven with the output register only while raw (unsynchronised) NOE is low and state=READ_DRV. Release is combinational on NOE high so there is no bus contention. Synchronised NOE rising → WAIT.
- WAIT→IDLE: after 16 clk with no strobe, or immediately when NADV falls (which goes to ADDR instead).
- NADV falling in any non-IDLE state aborts the current access: no wr_valid for an unfinished write, and the state goes to ADDR.
- NWE and NOE both low simultaneously: write has priority and the read is ignored.
- Out-of-range index (≥ NUM_CS): cs=0, wr_valid suppressed, reads return 0, err set. err clears only on reset.
- An index field that overflows AD_W is a parameter error and must be caught by an elaboration-time check.

Optional Feature:
FSMC_BURST_EN. When defined, each completed write (wr_valid) or read (NOE rise) in WAIT increments addr by 1, wrapping at 2^AD_W, and re-decodes cs. This supports consecutive strobes after a single NADV. When undefined, addr stays fixed until the next NADV, and repeated strobes target the same address.

Test Plan:
1. Reset: hold reset_n=0 while AD is being driven → AD=Z, outputs 0; release reset → state=IDLE.
2. Write: NADV low with AD=0x10000, NADV high, NWE low with AD=0x0F0F, NWE high → addr=0x10000, cs=0b0010, wr_data=0x0F0F, wr_valid high exactly 1 clk.
3. Read: address 0x10000, NOE low, rd_data=0x2321 → rd_req pulses once; AD=0x02321 while NOE low; AD=Z within the same delta after NOE rises.
4. Abort: NWE low, then NADV falls before NWE rises → no wr_valid; new address latched.
5. Out-of-range: NUM_CS=3, address 0x30000 with a write → cs=0, no wr_valid, err=1; a subsequent read returns 0.
6. Burst (FSMC_BURST_EN): one NADV at 0x00005 followed by three writes 0xA,0xB,0xC → wr_valid×3 at addresses 0x5, 0x6, 0x7. Without the macro, all three writes target 0x5.
